// File: rtl/gpio_bank_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gpio_bank_ctrl
//
// Parametrised GPIO peripheral on the ic0 bus. A single instance provides
// NUM_BANKS banks of WIDTH pins. Each pin has a direction bit, an output
// latch with set/clear aliases, and an input synchroniser. Selectable-polarity
// edge detection feeds a write-one-to-clear STATUS register. The enabled
// STATUS bits are combined into one registered irq line.
//
// Register window: BASE_ADDR .. BASE_ADDR + 2^ADDR_W - 1. Each bank occupies
// 0x20 bytes:
//   0x00 DATA_OUT rw   0x04 DIR rw (1=drive)   0x08 DATA_IN ro
//   0x0C IRQ_EN  rw    0x10 IRQ_EDGE rw (0=rise,1=fall)
//   0x14 STATUS  r/w1c 0x18 SET wo             0x1C CLR wo
// ADDR_W must be at least 6 so that the bank-index field is non-empty.
//
// Ports:
//   clk                     system clock
//   c_sys_rst               synchronous active-high reset
//   data_io                 pins, bank b = data_io[b*WIDTH +: WIDTH]
//   ic0_c_axi_mst_wr_valid  one-cycle write strobe
//   ic0_axi_mst_wr_addr     write byte address
//   ic0_axi_mst_wr_data     write data (only [WIDTH-1:0] used)
//   ic0_c_axi_mst_rd_valid  one-cycle read strobe
//   ic0_axi_mst_rd_addr     read byte address
//   ic0_c_axi_slv_rd_ready  read data valid, one-cycle pulse a cycle after rd_valid
//   ic0_axi_slv_rd_data     read data, zero-extended
//   irq                     registered OR of (STATUS & IRQ_EN) over all banks
// ---------------------------------------------------------------------------
module gpio_bank_ctrl #(
    parameter int          NUM_BANKS   = 2,
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          ADDR_W      = 8
) (
    input  logic                       clk,
    input  logic                       c_sys_rst,
    inout  wire  [NUM_BANKS*WIDTH-1:0] data_io,
    input  logic                       ic0_c_axi_mst_wr_valid,
    input  logic [31:0]                ic0_axi_mst_wr_addr,
    input  logic [31:0]                ic0_axi_mst_wr_data,
    input  logic                       ic0_c_axi_mst_rd_valid,
    input  logic [31:0]                ic0_axi_mst_rd_addr,
    output logic                       ic0_c_axi_slv_rd_ready,
    output logic [31:0]                ic0_axi_slv_rd_data,
    output logic                       irq
);

    localparam int TOTAL  = NUM_BANKS * WIDTH;
    localparam int BANK_W = ADDR_W - 5;

    typedef enum logic [2:0] {
        REG_DATA_OUT = 3'd0,
        REG_DIR      = 3'd1,
        REG_DATA_IN  = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_IRQ_EDGE = 3'd4,
        REG_STATUS   = 3'd5,
        REG_SET      = 3'd6,
        REG_CLR      = 3'd7
    } regSel_e;

    // Address decode
    logic              wrHit;
    logic              rdHit;
    logic [BANK_W-1:0] wrBank;
    logic [BANK_W-1:0] rdBank;
    regSel_e           wrReg;
    regSel_e           rdReg;
    logic [WIDTH-1:0]  wrVal;

    // Architectural state
    logic [TOTAL-1:0]  dataOut_q, dataOut_d;
    logic [TOTAL-1:0]  dir_q, dir_d;
    logic [TOTAL-1:0]  irqEn_q, irqEn_d;
    logic [TOTAL-1:0]  irqEdge_q, irqEdge_d;
    logic [TOTAL-1:0]  status_q, status_d;
    logic [TOTAL-1:0]  sync_q [SYNC_STAGES];
    logic [TOTAL-1:0]  syncDly_q;

    logic [TOTAL-1:0]  pinsIn;
    logic [TOTAL-1:0]  w1cMask;
    logic [TOTAL-1:0]  edgeHit;
    logic [WIDTH-1:0]  rdVal;

    logic              rdReady_q, rdReady_d;
    logic [31:0]       rdData_q, rdData_d;
    logic              irq_q, irq_d;

    // Byte-lane bits and the write-data bits above WIDTH carry no meaning here.
    logic              unusedBits;
    assign unusedBits = ^{ic0_axi_mst_wr_addr[1:0], ic0_axi_mst_rd_addr[1:0],
                          ic0_axi_mst_wr_data};

    assign wrHit  = ic0_c_axi_mst_wr_valid &&
                    (ic0_axi_mst_wr_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign rdHit  = ic0_c_axi_mst_rd_valid &&
                    (ic0_axi_mst_rd_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign wrBank = ic0_axi_mst_wr_addr[ADDR_W-1:5];
    assign rdBank = ic0_axi_mst_rd_addr[ADDR_W-1:5];
    assign wrReg  = regSel_e'(ic0_axi_mst_wr_addr[4:2]);
    assign rdReg  = regSel_e'(ic0_axi_mst_rd_addr[4:2]);
    assign wrVal  = ic0_axi_mst_wr_data[WIDTH-1:0];

    // Write decode. Bank indices at or beyond NUM_BANKS never match the loop,
    // so those writes fall away without touching any state.
    always_comb begin
        dataOut_d = dataOut_q;
        dir_d     = dir_q;
        irqEn_d   = irqEn_q;
        irqEdge_d = irqEdge_q;
        w1cMask   = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wrHit && (int'(wrBank) == b)) begin
                case (wrReg)
                    REG_DATA_OUT: dataOut_d[b*WIDTH +: WIDTH] = wrVal;
                    REG_DIR:      dir_d[b*WIDTH +: WIDTH]     = wrVal;
                    REG_IRQ_EN:   irqEn_d[b*WIDTH +: WIDTH]   = wrVal;
                    REG_IRQ_EDGE: irqEdge_d[b*WIDTH +: WIDTH] = wrVal;
                    REG_STATUS:   w1cMask[b*WIDTH +: WIDTH]   = wrVal;
                    REG_SET:      dataOut_d[b*WIDTH +: WIDTH] =
                                      dataOut_q[b*WIDTH +: WIDTH] | wrVal;
                    REG_CLR:      dataOut_d[b*WIDTH +: WIDTH] =
                                      dataOut_q[b*WIDTH +: WIDTH] & ~wrVal;
                    default:      ;
                endcase
            end
        end
    end

    // Edge detection compares the synchronised input with its one-cycle-old
    // copy. A fresh edge is OR-ed in after the W1C mask so a clear can never
    // swallow an edge that arrives in the same cycle.
    assign pinsIn   = sync_q[SYNC_STAGES-1];
    assign edgeHit  = (pinsIn & ~syncDly_q & ~irqEdge_q) |
                      (~pinsIn & syncDly_q & irqEdge_q);
    assign status_d = (status_q & ~w1cMask) | edgeHit;
    assign irq_d    = |(status_q & irqEn_q);

    // Read mux. Everything is sourced from current-state registers, so a read
    // that coincides with a write to the same register returns the old value.
    always_comb begin
        rdVal     = '0;
        rdData_d  = '0;
        rdReady_d = rdHit;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(rdBank) == b) begin
                case (rdReg)
                    REG_DATA_OUT: rdVal = dataOut_q[b*WIDTH +: WIDTH];
                    REG_DIR:      rdVal = dir_q[b*WIDTH +: WIDTH];
                    REG_DATA_IN:  rdVal = pinsIn[b*WIDTH +: WIDTH];
                    REG_IRQ_EN:   rdVal = irqEn_q[b*WIDTH +: WIDTH];
                    REG_IRQ_EDGE: rdVal = irqEdge_q[b*WIDTH +: WIDTH];
                    REG_STATUS:   rdVal = status_q[b*WIDTH +: WIDTH];
                    default:      rdVal = '0;
                endcase
            end
        end
        if (rdHit) begin
            rdData_d[WIDTH-1:0] = rdVal;
        end
    end

    // State registers. Reset wins over any bus access sampled on the same edge,
    // which also drops a read response that would otherwise be pending.
    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            dataOut_q <= '0;
            dir_q     <= '0;
            irqEn_q   <= '0;
            irqEdge_q <= '0;
            status_q  <= '0;
            syncDly_q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            rdReady_q <= 1'b0;
            rdData_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            dataOut_q <= dataOut_d;
            dir_q     <= dir_d;
            irqEn_q   <= irqEn_d;
            irqEdge_q <= irqEdge_d;
            status_q  <= status_d;
            sync_q[0] <= data_io;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            syncDly_q <= pinsIn;
            rdReady_q <= rdReady_d;
            rdData_q  <= rdData_d;
            irq_q     <= irq_d;
        end
    end

    // Per-pin tristate driver.
    for (genvar i = 0; i < TOTAL; i++) begin : g_pin
        assign data_io[i] = dir_q[i] ? dataOut_q[i] : 1'bz;
    end

    assign ic0_c_axi_slv_rd_ready = rdReady_q;
    assign ic0_axi_slv_rd_data    = rdData_q;
    assign irq                    = irq_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_gpio_bank_ctrl
//
// Two instances: the default 2x8 configuration (dut0) and a 4x32 build (dut1).
// Read stimulus pushes the expected word and the cycle on which the response
// must appear into a per-instance queue; a monitor per instance pops and
// compares whenever rd_ready is seen. Pin and irq levels are compared directly
// by the stimulus process.
// ---------------------------------------------------------------------------
module tb_gpio_bank_ctrl;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } sbItem_t;

    logic        clk;
    logic        c_sys_rst;
    int          cycleCnt;
    int          checks;
    int          errors;

    // dut0 bus
    logic        wrValidA, rdValidA, rdReadyA, irqA;
    logic [31:0] wrAddrA, wrDataA, rdAddrA, rdDataA;
    wire  [15:0] pinsA;
    logic [15:0] tbEn;
    logic [15:0] tbVal;

    // dut1 bus
    logic        wrValidB, rdValidB, rdReadyB, irqB;
    logic [31:0] wrAddrB, wrDataB, rdAddrB, rdDataB;
    wire  [127:0] pinsB;

    sbItem_t     sbQ0[$];
    sbItem_t     sbQ1[$];

    gpio_bank_ctrl #(
        .NUM_BANKS(2), .WIDTH(8), .SYNC_STAGES(2),
        .BASE_ADDR(32'h8000_0000), .ADDR_W(8)
    ) u_dut0 (
        .clk                    (clk),
        .c_sys_rst              (c_sys_rst),
        .data_io                (pinsA),
        .ic0_c_axi_mst_wr_valid (wrValidA),
        .ic0_axi_mst_wr_addr    (wrAddrA),
        .ic0_axi_mst_wr_data    (wrDataA),
        .ic0_c_axi_mst_rd_valid (rdValidA),
        .ic0_axi_mst_rd_addr    (rdAddrA),
        .ic0_c_axi_slv_rd_ready (rdReadyA),
        .ic0_axi_slv_rd_data    (rdDataA),
        .irq                    (irqA)
    );

    gpio_bank_ctrl #(
        .NUM_BANKS(4), .WIDTH(32), .SYNC_STAGES(2),
        .BASE_ADDR(32'h8000_0000), .ADDR_W(8)
    ) u_dut1 (
        .clk                    (clk),
        .c_sys_rst              (c_sys_rst),
        .data_io                (pinsB),
        .ic0_c_axi_mst_wr_valid (wrValidB),
        .ic0_axi_mst_wr_addr    (wrAddrB),
        .ic0_axi_mst_wr_data    (wrDataB),
        .ic0_c_axi_mst_rd_valid (rdValidB),
        .ic0_axi_mst_rd_addr    (rdAddrB),
        .ic0_c_axi_slv_rd_ready (rdReadyB),
        .ic0_axi_slv_rd_data    (rdDataB),
        .irq                    (irqB)
    );

    // External pin drivers for dut0; only enabled on pins the DUT does not drive.
    for (genvar i = 0; i < 16; i++) begin : g_tbPin
        assign pinsA[i] = tbEn[i] ? tbVal[i] : 1'bz;
    end

    // 100 MHz clock and a cycle counter used to time read responses.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Scoreboard monitor for dut0: every rd_ready must match the oldest
    // outstanding read, both in data and in the cycle it appears on.
    always @(negedge clk) begin : mon0
        sbItem_t it;
        if (rdReadyA) begin
            checks++;
            if (sbQ0.size() == 0) begin
                errors++;
                $display("[TB] FAIL dut0 unexpected rd_ready: data=%h, no read outstanding", rdDataA);
            end else begin
                it = sbQ0.pop_front();
                if (rdDataA !== it.data || cycleCnt != it.cyc) begin
                    errors++;
                    $display("[TB] FAIL dut0 %s: got %h at cycle %0d, expected %h at cycle %0d",
                             it.name, rdDataA, cycleCnt, it.data, it.cyc);
                end
            end
        end
    end

    // Scoreboard monitor for dut1.
    always @(negedge clk) begin : mon1
        sbItem_t it;
        if (rdReadyB) begin
            checks++;
            if (sbQ1.size() == 0) begin
                errors++;
                $display("[TB] FAIL dut1 unexpected rd_ready: data=%h, no read outstanding", rdDataB);
            end else begin
                it = sbQ1.pop_front();
                if (rdDataB !== it.data || cycleCnt != it.cyc) begin
                    errors++;
                    $display("[TB] FAIL dut1 %s: got %h at cycle %0d, expected %h at cycle %0d",
                             it.name, rdDataB, cycleCnt, it.data, it.cyc);
                end
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: inputs driven on the falling edge, sampled on the next
    // rising edge, then released 1 ns after it.
    task automatic applyStimulus(input int sel, input logic rst,
                                 input logic doWr, input logic [31:0] wa, input logic [31:0] wd,
                                 input logic doRd, input logic [31:0] ra,
                                 input logic expRdy, input logic [31:0] expData,
                                 input string name);
        sbItem_t it;
        @(negedge clk);
        c_sys_rst = rst;
        if (sel == 0) begin
            wrValidA = doWr; wrAddrA = wa; wrDataA = wd;
            rdValidA = doRd; rdAddrA = ra;
        end else begin
            wrValidB = doWr; wrAddrB = wa; wrDataB = wd;
            rdValidB = doRd; rdAddrB = ra;
        end
        if (doRd && expRdy) begin
            it.data = expData;
            it.cyc  = cycleCnt + 1;
            it.name = name;
            if (sel == 0) sbQ0.push_back(it);
            else          sbQ1.push_back(it);
        end
        @(posedge clk);
        #1;
        c_sys_rst = 1'b0;
        wrValidA = 1'b0; rdValidA = 1'b0;
        wrValidB = 1'b0; rdValidB = 1'b0;
    endtask

    task automatic wrReg(input int sel, input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(sel, 1'b0, 1'b1, addr, data, 1'b0, 32'h0, 1'b0, 32'h0, "");
    endtask

    task automatic rdReg(input int sel, input logic [31:0] addr, input logic [31:0] exp, input string name);
        applyStimulus(sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, addr, 1'b1, exp, name);
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        c_sys_rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset irq0", {31'b0, irqA}, 32'h0);
        checkOutput("reset rd_ready0", {31'b0, rdReadyA}, 32'h0);
        checkOutput("reset rd_data0", rdDataA, 32'h0);
        checkOutput("reset irq1", {31'b0, irqB}, 32'h0);
        c_sys_rst = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        c_sys_rst = 1'b1;
        wrValidA = 0; wrAddrA = 0; wrDataA = 0; rdValidA = 0; rdAddrA = 0;
        wrValidB = 0; wrAddrB = 0; wrDataB = 0; rdValidB = 0; rdAddrB = 0;
        tbEn  = 16'hFFFF;
        tbVal = 16'h0000;

        // ---------------- reset state ----------------
        resetDut();
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
                rdReg(0, 32'h8000_0000 + 32'(b*32 + r*4), 32'h0,
                      $sformatf("reset b%0d off %0h", b, r*4));
            end
        end

        // Pins undriven by the DUT: the external pattern must be read back.
        tbVal = 16'h3CC3;
        waitEdges(3);
        rdReg(0, 32'h8000_0008, 32'h0000_00C3, "hi-z DATA_IN b0");
        rdReg(0, 32'h8000_0028, 32'h0000_003C, "hi-z DATA_IN b1");
        rdReg(0, 32'h8000_0014, 32'h0000_00C3, "rise STATUS b0");
        rdReg(0, 32'h8000_0034, 32'h0000_003C, "rise STATUS b1");
        tbVal = 16'h0000;
        waitEdges(4);
        resetDut();
        rdReg(0, 32'h8000_0014, 32'h0, "STATUS b0 after reset");
        rdReg(0, 32'h8000_0034, 32'h0, "STATUS b1 after reset");

        // ---------------- output path ----------------
        wrReg(0, 32'h8000_0020, 32'h0000_00A5);
        tbEn[15:8] = 8'h00;
        wrReg(0, 32'h8000_0024, 32'h0000_00FF);
        checkOutput("pins b1 A5", {24'h0, pinsA[15:8]}, 32'h0000_00A5);
        wrReg(0, 32'h8000_0038, 32'h0000_000A);
        checkOutput("pins b1 SET", {24'h0, pinsA[15:8]}, 32'h0000_00AF);
        wrReg(0, 32'h8000_003C, 32'h0000_0005);
        checkOutput("pins b1 CLR", {24'h0, pinsA[15:8]}, 32'h0000_00AA);
        waitEdges(2);
        rdReg(0, 32'h8000_0028, 32'h0000_00AA, "DATA_IN b1 readback");
        rdReg(0, 32'h8000_0020, 32'h0000_00AA, "DATA_OUT b1");
        rdReg(0, 32'h8000_0024, 32'h0000_00FF, "DIR b1");
        wrReg(0, 32'h8000_0022, 32'hDEAD_BE55);
        checkOutput("pins b1 upper bits ignored", {24'h0, pinsA[15:8]}, 32'h0000_0055);
        rdReg(0, 32'h8000_0021, 32'h0000_0055, "DATA_OUT b1 byte lanes ignored");

        // ---------------- read timing and decode ----------------
        rdReg(0, 32'h8000_0008, 32'h0, "DATA_IN b0 timing");
        checkOutput("rd_ready one cycle later", {31'b0, rdReadyA}, 32'h1);
        waitEdges(1);
        checkOutput("rd_ready single pulse", {31'b0, rdReadyA}, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h9000_0000, 1'b0, 32'h0, "");
        checkOutput("non-hit rd_ready", {31'b0, rdReadyA}, 32'h0);
        checkOutput("non-hit rd_data", rdDataA, 32'h0);
        wrReg(0, 32'h9000_0020, 32'h0000_0000);
        rdReg(0, 32'h8000_0020, 32'h0000_0055, "non-hit write ignored");
        rdReg(0, 32'h8000_0040, 32'h0, "bank2 read");
        rdReg(0, 32'h8000_0038, 32'h0, "SET reads 0");
        rdReg(0, 32'h8000_003C, 32'h0, "CLR reads 0");
        applyStimulus(0, 1'b0, 1'b1, 32'h8000_0020, 32'h0000_0077,
                      1'b1, 32'h8000_0020, 1'b1, 32'h0000_0055, "same-cycle wr/rd old value");
        rdReg(0, 32'h8000_0024, 32'h0000_00FF, "b2b DIR b1");
        rdReg(0, 32'h8000_0020, 32'h0000_0077, "b2b DATA_OUT b1");
        rdReg(0, 32'h8000_0008, 32'h0, "b2b DATA_IN b0");

        // ---------------- interrupts ----------------
        wrReg(0, 32'h8000_000C, 32'h0000_0001);
        @(negedge clk); tbVal[0] = 1'b1;
        waitEdges(3);
        checkOutput("irq before rise registered", {31'b0, irqA}, 32'h0);
        rdReg(0, 32'h8000_0014, 32'h0000_0001, "STATUS rise");
        checkOutput("irq after rise", {31'b0, irqA}, 32'h1);
        wrReg(0, 32'h8000_0014, 32'h0000_0001);
        checkOutput("irq holds one cycle after W1C", {31'b0, irqA}, 32'h1);
        waitEdges(1);
        checkOutput("irq drops after W1C", {31'b0, irqA}, 32'h0);
        rdReg(0, 32'h8000_0014, 32'h0, "STATUS cleared");

        wrReg(0, 32'h8000_0010, 32'h0000_0001);
        @(negedge clk); tbVal[0] = 1'b0;
        waitEdges(3);
        checkOutput("irq before fall registered", {31'b0, irqA}, 32'h0);
        rdReg(0, 32'h8000_0014, 32'h0000_0001, "STATUS fall");
        checkOutput("irq after fall", {31'b0, irqA}, 32'h1);
        wrReg(0, 32'h8000_0014, 32'h0000_0001);
        waitEdges(1);
        checkOutput("irq drops after fall W1C", {31'b0, irqA}, 32'h0);

        @(negedge clk); tbVal[0] = 1'b1;
        waitEdges(4);
        rdReg(0, 32'h8000_0014, 32'h0, "rise ignored when EDGE=1");
        checkOutput("irq stays low on wrong polarity", {31'b0, irqA}, 32'h0);

        @(negedge clk); tbVal[1] = 1'b1;
        waitEdges(4);
        rdReg(0, 32'h8000_0014, 32'h0000_0002, "STATUS set while IRQ_EN off");
        checkOutput("irq masked by IRQ_EN", {31'b0, irqA}, 32'h0);
        wrReg(0, 32'h8000_0014, 32'h0000_0002);

        // Falling edge on pin0 lands on the same edge as the W1C of bit 0.
        @(negedge clk); tbVal[0] = 1'b0;
        repeat (2) @(posedge clk);
        wrReg(0, 32'h8000_0014, 32'h0000_0001);
        rdReg(0, 32'h8000_0014, 32'h0000_0001, "set wins over W1C");

        // ---------------- reset priority ----------------
        applyStimulus(0, 1'b1, 1'b1, 32'h8000_0004, 32'h0000_00FF,
                      1'b1, 32'h8000_0000, 1'b0, 32'h0, "");
        checkOutput("reset suppresses rd_ready", {31'b0, rdReadyA}, 32'h0);
        checkOutput("reset clears irq", {31'b0, irqA}, 32'h0);
        tbVal[15:8] = 8'h00;
        tbEn[15:8]  = 8'hFF;
        rdReg(0, 32'h8000_0004, 32'h0, "write during reset ignored");
        rdReg(0, 32'h8000_0020, 32'h0, "DATA_OUT b1 after reset");
        rdReg(0, 32'h8000_0014, 32'h0, "STATUS b0 after reset");

        // ---------------- 4x32 configuration ----------------
        wrReg(1, 32'h8000_0060, 32'hDEAD_BEEF);
        rdReg(1, 32'h8000_0060, 32'hDEAD_BEEF, "big b3 DATA_OUT");
        wrReg(1, 32'h8000_006C, 32'hF0F0_1234);
        rdReg(1, 32'h8000_006C, 32'hF0F0_1234, "big b3 IRQ_EN");
        rdReg(1, 32'h8000_0064, 32'h0, "big b3 DIR");
        rdReg(1, 32'h8000_0080, 32'h0, "big bank4 read");
        rdReg(1, 32'h8000_00E0, 32'h0, "big bank7 read");
        wrReg(1, 32'h8000_0080, 32'hFFFF_FFFF);
        rdReg(1, 32'h8000_0000, 32'h0, "big bank4 write no alias");

        // ---------------- drain ----------------
        waitEdges(3);
        checkOutput("dut0 responses outstanding", 32'(sbQ0.size()), 32'h0);
        checkOutput("dut1 responses outstanding", 32'(sbQ1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
